// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   XLEN          : core data/address width
//   F3_*          : RISC-V load/store funct3 encodings
//   state_t       : responder FSM encoding
//   f3_is_legal() : funct3 values that name a real load/store width
package data_ram_responder_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic f3_is_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// Load/store request and response channel between the core memory stage
// (master) and the data RAM responder (slave).
//   req_*  : request channel, valid/ready handshake, held by the core
//   resp_* : response channel, valid/ready handshake, held by the responder
interface data_ram_responder_if #(
  parameter int XLEN = data_ram_responder_pkg::XLEN
) ();

  logic            req_valid_i;
  logic            req_ready_o;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            req_we_i;
  logic [2:0]      req_func3_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_rdata_o;
  logic            resp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_func3_i,
    output resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_func3_i,
    input  resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

endinterface

// File: rtl/data_ram_responder_mem_lane_align.sv
// Combinational byte-lane logic for RISC-V loads and stores on a 32-bit RAM.
//   func3, addr, we : access descriptor
//   wdata           : right-aligned store data
//   rword           : word read from the RAM
//   be              : byte enables for the store
//   wdata_lane      : store data replicated onto every lane it may target
//   rdata_ext       : selected and sign/zero-extended load data
//   err             : illegal funct3, misaligned, or address beyond the RAM
module data_ram_responder_mem_lane_align #(
  parameter int XLEN        = data_ram_responder_pkg::XLEN,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext,
  output logic            err
);
  import data_ram_responder_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] addr_high;
  logic [XLEN-1:0] byte_shifted;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;

  // Anything left after dropping the in-range byte offset is out of range.
  assign addr_high = addr >> (AW + 2);

  always_comb begin
    err = 1'b0;
    if (!f3_is_legal(func3))                err = 1'b1;
    if (we && func3[2])                     err = 1'b1;
    if (func3[1:0] == 2'b01 && addr[0])     err = 1'b1;
    if (func3[1:0] == 2'b10 && addr[1:0] != 2'b00) err = 1'b1;
    if (|addr_high)                         err = 1'b1;
  end

  // Replicating the data lets the byte enables alone pick the target lane.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (func3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr[1:0];
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  assign byte_shifted = rword >> {addr[1:0], 3'b000};
  assign sel_byte     = byte_shifted[7:0];
  assign sel_half     = addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rdata_ext = rword;
    case (func3)
      F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata_ext = {24'd0, sel_byte};
      F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata_ext = {16'd0, sel_half};
      default: rdata_ext = rword;
    endcase
  end

endmodule

// File: rtl/data_ram_responder.sv
// Data-memory responder for the core memory stage.
// Accepts one load/store per request handshake, waits WAIT_CYCLES, performs
// one RAM access, and holds the response until the core takes it.
//   clk_i : clock
//   rst_i : asynchronous active-high reset (RAM contents are kept)
//   mem   : request/response channel, slave side
module data_ram_responder #(
  parameter int XLEN        = data_ram_responder_pkg::XLEN,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_ram_responder_if.slave  mem
);
  import data_ram_responder_pkg::*;

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t          state_reg, state_next;
  logic [3:0]      wait_cnt_reg, wait_cnt_next;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            we_reg;
  logic [2:0]      func3_reg;
  logic            err_reg;

  logic            accept;
  logic            in_idle;
  logic [2:0]      align_func3;
  logic [XLEN-1:0] align_addr;
  logic            align_we;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_lane;
  logic [XLEN-1:0] rdata_ext;
  logic            req_err;
  logic [XLEN-1:0] rword;
  logic [AW-1:0]   word_idx;
  logic            wr_en;
  logic            rd_en;

  assign in_idle         = (state_reg == ST_IDLE);
  assign mem.req_ready_o = in_idle;
  assign accept          = mem.req_valid_i && in_idle;

  // In IDLE the error decode looks at the live request so the first state
  // after the handshake is already known; afterwards the captured copy drives
  // lane selection and load extension.
  assign align_func3 = in_idle ? mem.req_func3_i : func3_reg;
  assign align_addr  = in_idle ? mem.req_addr_i  : addr_reg;
  assign align_we    = in_idle ? mem.req_we_i    : we_reg;

  data_ram_responder_mem_lane_align #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_align (
    .func3      (align_func3),
    .addr       (align_addr),
    .we         (align_we),
    .wdata      (wdata_reg),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (req_err)
  );

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem.req_valid_i) begin
          if (req_err) begin
            state_next = ST_RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = ST_ACCESS;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP: begin
        if (mem.resp_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 4'd0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      func3_reg    <= 3'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        addr_reg  <= mem.req_addr_i;
        wdata_reg <= mem.req_wdata_i;
        we_reg    <= mem.req_we_i;
        func3_reg <= mem.req_func3_i;
        err_reg   <= req_err;
      end
    end
  end

  // Erroring requests never reach ACCESS, so no extra error gating is needed.
  // Because the state register resets asynchronously, a reset before the
  // ACCESS edge also cancels the write.
  assign word_idx = addr_reg[AW+1:2];
  assign wr_en    = (state_reg == ST_ACCESS) && we_reg;
  assign rd_en    = (state_reg == ST_ACCESS) && !we_reg;

  // One byte-wide array per lane keeps each lane a simple
  // write-enable RAM with a registered read port.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram_lane [DEPTH_WORDS];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge clk_i) begin
      if (wr_en && be[gi]) ram_lane[word_idx] <= wdata_lane[gi*8 +: 8];
      if (rd_en)           rd_byte_reg        <= ram_lane[word_idx];
    end

    assign rword[gi*8 +: 8] = rd_byte_reg;
  end

  assign mem.resp_valid_o = (state_reg == ST_RESP);
  assign mem.resp_err_o   = (state_reg == ST_RESP) && err_reg;
  assign mem.resp_rdata_o = ((state_reg == ST_RESP) && !we_reg && !err_reg) ? rdata_ext : '0;

endmodule
